// File: rtl/pipeline_hazard_sequencer_if.sv
// Pipeline control bundle shared by the hazard sequencer and the core datapath.
// The core (master) supplies decode/EX/MEM hazard information; the sequencer
// (slave) returns the per-stage enable, flush and bubble controls.
interface pipeline_hazard_sequencer_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_load_inst;
    logic                  ex_reg_dest;
    logic                  ex_redirect;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  pc_en;
    logic                  if_id_en;
    logic                  if_id_flush;
    logic                  id_ex_en;
    logic                  id_ex_bubble;
    logic                  ex_mem_en;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_load_inst, ex_reg_dest, ex_redirect,
        output mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_load_inst, ex_reg_dest, ex_redirect,
        input  mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en
    );
endinterface

// File: rtl/pipeline_hazard_sequencer.sv
// Five-stage pipeline sequencer: resolves load-use hazards, data-memory wait
// stalls and EX-stage redirects, and drives the stage enable/flush/bubble
// controls. Also tracks stalled cycles and a sticky memory-timeout flag.
module pipeline_hazard_sequencer #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    pipeline_hazard_sequencer_if.slave hz,
    input  logic                     perf_clr,
    output logic                     mem_timeout,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [1:0]               state_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam int WC_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WC_W-1:0] WAIT_LIMIT   = WC_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_FLUSH   = 2'b10
    } state_t;

    state_t          state_reg, state_next;
    logic [FC_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic [WC_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic            release_reg, release_next;
    logic            timeout_set;
    logic            eval_run;

    // Per-source load-use match against the EX destination register
    logic [REG_ADDR_W-1:0] src_reg [2];
    logic [1:0]            src_use;
    logic [1:0]            src_hit;
    logic                  lu;
    logic                  ms;
    logic                  ms_eff;

    assign src_reg[0] = hz.id_rs1;
    assign src_reg[1] = hz.id_rs2;
    assign src_use    = {hz.id_uses_rs2, hz.id_uses_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_reg[gi] == hz.ex_rd);
        end
    endgenerate

    // Stores and x0 destinations never produce a writeback to wait for
    assign lu = hz.ex_load_inst && !hz.ex_reg_dest && (hz.ex_rd != '0) && (|src_hit);
    assign ms = hz.mem_req && !hz.mem_ready;
    // A timed-out access is released for one cycle as though it completed
    assign ms_eff = ms && !release_reg;

    assign state_o = state_reg;

    // Next-state and stage control decode
    always_comb begin
        hz.pc_en        = 1'b1;
        hz.if_id_en     = 1'b1;
        hz.id_ex_en     = 1'b1;
        hz.ex_mem_en    = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        state_next      = state_reg;
        flush_cnt_next  = flush_cnt_reg;
        wait_cnt_next   = wait_cnt_reg;
        release_next    = 1'b0;
        timeout_set     = 1'b0;
        eval_run        = 1'b0;

        case (state_reg)
            ST_RUN: begin
                if (ms_eff) begin
                    hz.pc_en      = 1'b0;
                    hz.if_id_en   = 1'b0;
                    hz.id_ex_en   = 1'b0;
                    hz.ex_mem_en  = 1'b0;
                    state_next    = ST_MEMWAIT;
                    wait_cnt_next = WC_W'(1);
                end else begin
                    eval_run = 1'b1;
                end
            end
            ST_MEMWAIT: begin
                if (ms_eff) begin
                    hz.pc_en     = 1'b0;
                    hz.if_id_en  = 1'b0;
                    hz.id_ex_en  = 1'b0;
                    hz.ex_mem_en = 1'b0;
                    if ((MEM_TIMEOUT != 0) && (wait_cnt_reg == WAIT_LIMIT)) begin
                        timeout_set   = 1'b1;
                        release_next  = 1'b1;
                        state_next    = ST_RUN;
                        wait_cnt_next = '0;
                    end else if (wait_cnt_reg != '1) begin
                        wait_cnt_next = wait_cnt_reg + WC_W'(1);
                    end
                end else begin
                    wait_cnt_next = '0;
                    eval_run      = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (ms_eff) begin
                    hz.pc_en     = 1'b0;
                    hz.if_id_en  = 1'b0;
                    hz.id_ex_en  = 1'b0;
                    hz.ex_mem_en = 1'b0;
                end else if (hz.ex_redirect) begin
                    eval_run = 1'b1;
                end else if (lu) begin
                    // Hold the flush count while the decode slot is stalled
                    hz.pc_en        = 1'b0;
                    hz.if_id_en     = 1'b0;
                    hz.id_ex_bubble = 1'b1;
                end else begin
                    hz.if_id_flush = 1'b1;
                    flush_cnt_next = flush_cnt_reg - FC_W'(1);
                    if (flush_cnt_reg == FC_W'(1)) begin
                        state_next = ST_RUN;
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase

        // Shared run-mode evaluation once no memory stall is pending
        if (eval_run) begin
            state_next = ST_RUN;
            if (hz.ex_redirect) begin
                hz.if_id_flush  = 1'b1;
                hz.id_ex_bubble = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_RELOAD;
                end
            end else if (lu) begin
                hz.pc_en        = 1'b0;
                hz.if_id_en     = 1'b0;
                hz.id_ex_bubble = 1'b1;
            end
        end

        if (reset) begin
            hz.pc_en        = 1'b0;
            hz.if_id_en     = 1'b0;
            hz.id_ex_en     = 1'b0;
            hz.ex_mem_en    = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
        end
    end

    // State, counters and sticky flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= '0;
            wait_cnt_reg  <= '0;
            release_reg   <= 1'b0;
            mem_timeout   <= 1'b0;
            stall_cycles  <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            wait_cnt_reg  <= wait_cnt_next;
            release_reg   <= release_next;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
            if (perf_clr) begin
                stall_cycles <= '0;
            end else if (!hz.pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for the pipeline hazard sequencer. Control outputs are
// viewed as {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_bubble}.
module tb_pipeline_hazard_sequencer;

    localparam logic [5:0] C_RUN    = 6'b111100;
    localparam logic [5:0] C_FREEZE = 6'b000000;
    localparam logic [5:0] C_LU     = 6'b001101;
    localparam logic [5:0] C_REDIR  = 6'b111111;
    localparam logic [5:0] C_FLUSH  = 6'b111110;
    localparam logic [5:0] C_RESET  = 6'b000011;

    logic        clk = 1'b0;
    logic        reset;
    logic        perf_clr;
    logic        mem_timeout;
    logic [15:0] stall_cycles;
    logic [1:0]  state_o;
    logic [5:0]  ctrl;
    int          tests = 0;
    int          fails = 0;

    pipeline_hazard_sequencer_if #(.REG_ADDR_W(5)) hz_if ();

    pipeline_hazard_sequencer #(
        .REG_ADDR_W  (5),
        .FLUSH_CYCLES(2),
        .MEM_TIMEOUT (4),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hz          (hz_if),
        .perf_clr    (perf_clr),
        .mem_timeout (mem_timeout),
        .stall_cycles(stall_cycles),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    assign ctrl = {hz_if.pc_en, hz_if.if_id_en, hz_if.id_ex_en, hz_if.ex_mem_en,
                   hz_if.if_id_flush, hz_if.id_ex_bubble};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock, leaving time just past the edge for new stimulus
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        hz_if.id_rs1       = 5'd0;
        hz_if.id_rs2       = 5'd0;
        hz_if.id_uses_rs1  = 1'b0;
        hz_if.id_uses_rs2  = 1'b0;
        hz_if.ex_rd        = 5'd0;
        hz_if.ex_load_inst = 1'b0;
        hz_if.ex_reg_dest  = 1'b0;
        hz_if.ex_redirect  = 1'b0;
        hz_if.mem_req      = 1'b0;
        hz_if.mem_ready    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        perf_clr = 1'b0;
        reset    = 1'b1;
        tick();
        tick();
        #2;
        check("reset_ctrl", 32'(ctrl), 32'(C_RESET));
        check("reset_state", 32'(state_o), 32'd0);
        check("reset_stall", 32'(stall_cycles), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        tick();

        // Idle run
        reset = 1'b0;
        #2;
        check("idle_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();

        // lw x5 in EX, ID reads x5 on rs2
        hz_if.ex_load_inst = 1'b1;
        hz_if.ex_rd        = 5'd5;
        hz_if.id_rs2       = 5'd5;
        hz_if.id_uses_rs2  = 1'b1;
        #2;
        check("lu_ctrl", 32'(ctrl), 32'(C_LU));
        check("lu_state", 32'(state_o), 32'd0);
        tick();
        hz_if.ex_load_inst = 1'b0;
        #2;
        check("lu_after_ctrl", 32'(ctrl), 32'(C_RUN));
        check("lu_stall", 32'(stall_cycles), 32'd1);
        tick();

        // Store to x5 with matching source: no hazard
        hz_if.ex_load_inst = 1'b1;
        hz_if.ex_reg_dest  = 1'b1;
        #2;
        check("store_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        // Load to x0 with matching rs1
        idle_inputs();
        hz_if.ex_load_inst = 1'b1;
        hz_if.id_uses_rs1  = 1'b1;
        #2;
        check("load_x0_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();
        // Load x7 matching rs1 value but rs1 unused
        hz_if.ex_rd       = 5'd7;
        hz_if.id_rs1      = 5'd7;
        hz_if.id_uses_rs1 = 1'b0;
        #2;
        check("unused_rs_ctrl", 32'(ctrl), 32'(C_RUN));
        check("no_stall_count", 32'(stall_cycles), 32'd1);
        tick();
        idle_inputs();

        // Memory stall: three not-ready cycles, then ready
        hz_if.mem_req = 1'b1;
        #2;
        check("ms1_ctrl", 32'(ctrl), 32'(C_FREEZE));
        check("ms1_state", 32'(state_o), 32'd0);
        tick();
        #2;
        check("ms2_ctrl", 32'(ctrl), 32'(C_FREEZE));
        check("ms2_state", 32'(state_o), 32'd1);
        tick();
        #2;
        check("ms3_ctrl", 32'(ctrl), 32'(C_FREEZE));
        check("ms3_state", 32'(state_o), 32'd1);
        tick();
        hz_if.mem_ready = 1'b1;
        #2;
        check("ms_rel_ctrl", 32'(ctrl), 32'(C_RUN));
        check("ms_rel_state", 32'(state_o), 32'd1);
        tick();
        idle_inputs();
        #2;
        check("ms_done_state", 32'(state_o), 32'd0);
        check("ms_stall", 32'(stall_cycles), 32'd4);
        tick();

        // Counter clear
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        #2;
        check("perf_clr_stall", 32'(stall_cycles), 32'd0);
        tick();

        // Redirect pulse with two flush cycles
        hz_if.ex_redirect = 1'b1;
        #2;
        check("redir_ctrl", 32'(ctrl), 32'(C_REDIR));
        check("redir_state", 32'(state_o), 32'd0);
        tick();
        hz_if.ex_redirect = 1'b0;
        #2;
        check("flush_ctrl", 32'(ctrl), 32'(C_FLUSH));
        check("flush_state", 32'(state_o), 32'd2);
        tick();
        #2;
        check("flush_done_ctrl", 32'(ctrl), 32'(C_RUN));
        check("flush_done_state", 32'(state_o), 32'd0);
        tick();

        // Redirect and load-use together: redirect wins
        hz_if.ex_redirect  = 1'b1;
        hz_if.ex_load_inst = 1'b1;
        hz_if.ex_rd        = 5'd9;
        hz_if.id_rs1       = 5'd9;
        hz_if.id_uses_rs1  = 1'b1;
        #2;
        check("redir_lu_ctrl", 32'(ctrl), 32'(C_REDIR));
        tick();
        idle_inputs();
        #2;
        check("redir_lu_flush", 32'(ctrl), 32'(C_FLUSH));
        tick();
        #2;
        check("redir_lu_state", 32'(state_o), 32'd0);
        tick();

        // Memory stall with redirect: freeze first, redirect on ready
        hz_if.mem_req     = 1'b1;
        hz_if.ex_redirect = 1'b1;
        #2;
        check("ms_redir_freeze", 32'(ctrl), 32'(C_FREEZE));
        tick();
        hz_if.mem_ready = 1'b1;
        #2;
        check("ms_redir_ctrl", 32'(ctrl), 32'(C_REDIR));
        check("ms_redir_state", 32'(state_o), 32'd1);
        tick();
        idle_inputs();
        #2;
        check("ms_redir_flush", 32'(ctrl), 32'(C_FLUSH));
        check("ms_redir_fstate", 32'(state_o), 32'd2);
        tick();
        #2;
        check("ms_redir_run", 32'(state_o), 32'd0);
        check("ms_redir_stall", 32'(stall_cycles), 32'd1);
        tick();

        // Memory never ready: timeout after four MEMWAIT cycles
        hz_if.mem_req = 1'b1;
        #2;
        check("to_entry_ctrl", 32'(ctrl), 32'(C_FREEZE));
        tick();
        for (int i = 0; i < 4; i++) begin
            #2;
            check($sformatf("to_wait%0d_state", i), 32'(state_o), 32'd1);
            check($sformatf("to_wait%0d_flag", i), 32'(mem_timeout), 32'd0);
            tick();
        end
        hz_if.mem_req = 1'b0;
        #2;
        check("to_state", 32'(state_o), 32'd0);
        check("to_flag", 32'(mem_timeout), 32'd1);
        check("to_ctrl", 32'(ctrl), 32'(C_RUN));
        check("to_stall", 32'(stall_cycles), 32'd6);
        tick();

        // Reset in the middle of a memory wait
        hz_if.mem_req = 1'b1;
        tick();
        #2;
        check("rst_mid_state", 32'(state_o), 32'd1);
        tick();
        reset = 1'b1;
        #2;
        check("rst_mid_ctrl", 32'(ctrl), 32'(C_RESET));
        tick();
        reset = 1'b0;
        hz_if.mem_req = 1'b0;
        #2;
        check("rst_after_state", 32'(state_o), 32'd0);
        check("rst_after_flag", 32'(mem_timeout), 32'd0);
        check("rst_after_stall", 32'(stall_cycles), 32'd0);
        check("rst_after_ctrl", 32'(ctrl), 32'(C_RUN));
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
